csr_timer_ctrl: RTL
===================

// Module: csr_timer_ctrl
// PURPOSE
//  Timer/interrupt controller for the CSR file written by the WB stage. Owns TID, TCFG, TVAL, TICLR.
//  Counts TVAL down, raises the timer-interrupt pending bit (TI) and serves the CSR read/write port.
//  The timer_int output feeds ESTAT.IS[11] in the CSR file.
//  The interrupt is signalled into the pipeline as the int exception, taken at WB.
// PARAMETERS
//  TIMER_W    32      width of TVAL and of TCFG.InitVal field+2; 8..32
//  TID_RESET  32'h0   reset value of TID
// PORTS
//  clk          in   1        core clock
//  resetn       in   1        asynchronous reset, active-low
//  csr_re       in   1        CSR read enable (WB)
//  csr_num      in   14       CSR address (WB)
//  csr_we       in   1        CSR write enable (WB, already gated by ws_valid)
//  csr_wmask    in   32       per-bit write mask
//  csr_wvalue   in   32       write data
//  csr_hit      out  1        csr_num is TID/TCFG/TVAL/TICLR (0x40/0x41/0x42/0x44)
//  csr_rvalue   out  32       read data; 0 when !csr_re or !csr_hit
//  timer_int    out  1        TI pending (level)
//  cnt_value    out  64       stable counter (only with STABLE_CNT_EN, else 0)
// BEHAVIOUR
//  Reset (async, resetn=0): TID=TID_RESET, TCFG=0, TVAL={TIMER_W{1'b1}}, TI=0, counter=0.
//   Outputs follow from these regs: timer_int=0, cnt_value=0.
//  Writes take effect at the next posedge. Each written bit is (old & ~wmask) | (wvalue & wmask).
//  Reads are combinational from current register state; a write in the same cycle is not visible.
//  TCFG: bit0 En, bit1 Periodic, [TIMER_W-1:2] InitVal, other bits read 0.
//  TVAL is read-only; upper bits above TIMER_W read 0.
//  TICLR reads 0; writing with effective bit0=1 is CLR (clears TI).
//  TVAL state, one update per cycle, priority top-down:
//   1. TCFG write with new En=1 -> TVAL <= {new InitVal,2'b00}
//   2. En=1 & TVAL==0 & Periodic -> TVAL <= {InitVal,2'b00}
//   3. En=1 & TVAL!=all-ones -> TVAL <= TVAL-1. From 0 this wraps to all-ones.
//   4. else hold. A one-shot timer therefore parks at all-ones.
//   A TCFG write with En=0 only freezes TVAL.
//  TI set: En=1 & TVAL==0 (not case 1) -> TI<=1 next cycle. Latency InitVal*4+1 cycles from load to TI.
//  TI clear: CLR write. A simultaneous set and clear -> set wins, so no interrupt is lost.
//  InitVal=0 periodic: TVAL stays 0 and TI reasserts every cycle until En=0.
//  TID: plain R/W register, full 32 bits masked.
//  A reset asserted mid-count aborts immediately to the reset state and does not generate TI.
//  Writes to non-hit csr_num are ignored. csr_hit is combinational from csr_num.
// CONFIGURATION
//  STABLE_CNT_EN defined:
//   - A 64-bit free-running counter increments every cycle from reset and wraps at 2^64-1 to 0.
//   - cnt_value = counter, as used by rdcntvl/rdcntvh in EX.
//   - Not writable through CSR.
//  STABLE_CNT_EN undefined:
//   - No counter flops.
//   - cnt_value tied to 64'h0.
// TESTING
//  T1 reset:
//   - resetn low mid-count -> same cycle timer_int=0, TVAL reads FFFF_FFFF, TID reads TID_RESET.
//  T2 one-shot:
//   - write TCFG=0x11 (InitVal=4, En=1, Periodic=0) -> TVAL 16,15..0.
//   - timer_int rises 17 cycles after the write edge; TVAL then FFFF_FFFF and holds.
//  T3 periodic:
//   - write TCFG=0x0B (InitVal=2, En, Periodic) -> TVAL 8..0,8..0.
//   - TI set at first 0; write TICLR=1 -> TI cleared; TI sets again at next 0.
//  T4 collision:
//   - TICLR CLR write in the same cycle TVAL==0 & En -> timer_int stays 1.
//  T5 masked write/read:
//   - TID=0x1234_5678; write wvalue=FFFF_FFFF, wmask=0000_FF00 -> TID reads 0x1234_FF78.
//   - TICLR always reads 0; csr_num=0x43 -> csr_hit=0, csr_rvalue=0.
//  T6 config:
//   - STABLE_CNT_EN defined: cnt_value = N cycles after reset release.
//   - Force counter FFFF..FFFF -> 0 next cycle.
//   - STABLE_CNT_EN undefined: cnt_value = 0.

Source files
------------

// File: rtl/csr_timer_ctrl_if.sv
// CSR read/write port between the WB-stage CSR file and the timer controller.
// master drives the request; slave returns hit and read data.
interface csr_timer_ctrl_if;
    logic        csr_re;
    logic [13:0] csr_num;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        csr_hit;
    logic [31:0] csr_rvalue;

    modport master (
        output csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
        input  csr_hit, csr_rvalue
    );

    modport slave (
        input  csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
        output csr_hit, csr_rvalue
    );
endinterface

// File: rtl/csr_timer_ctrl.sv
// Timer/interrupt controller owning TID, TCFG, TVAL and TICLR; drives the TI pending bit.
// Optional macro STABLE_CNT_EN adds a 64-bit free-running stable counter on cnt_value.
module csr_timer_ctrl #(
    parameter int unsigned TIMER_W   = 32,
    parameter logic [31:0] TID_RESET = 32'h0
) (
    input  logic                clk,
    input  logic                resetn,
    csr_timer_ctrl_if.slave     csr,
    output logic                timer_int,
    output logic [63:0]         cnt_value
);

    localparam logic [13:0] CsrTid   = 14'h40;
    localparam logic [13:0] CsrTcfg  = 14'h41;
    localparam logic [13:0] CsrTval  = 14'h42;
    localparam logic [13:0] CsrTiclr = 14'h44;

    localparam logic [TIMER_W-1:0] TvalOne = {{(TIMER_W-1){1'b0}}, 1'b1};

    logic [31:0]        tid_q, tid_d;
    logic [TIMER_W-1:0] tcfg_q, tcfg_d;
    logic [TIMER_W-1:0] tval_q, tval_d;
    logic               ti_q, ti_d;

    logic               tid_we, tcfg_we, ticlr_we;
    logic [TIMER_W-1:0] tcfg_wr_val;
    logic               en, periodic;
    logic               tval_zero, tval_ones;
    logic               load_now, ti_set, ti_clr;

    always_comb begin
        unique case (csr.csr_num)
            CsrTid, CsrTcfg, CsrTval, CsrTiclr: csr.csr_hit = 1'b1;
            default:                            csr.csr_hit = 1'b0;
        endcase
    end

    assign tid_we   = csr.csr_we && (csr.csr_num == CsrTid);
    assign tcfg_we  = csr.csr_we && (csr.csr_num == CsrTcfg);
    assign ticlr_we = csr.csr_we && (csr.csr_num == CsrTiclr);

    assign tcfg_wr_val = (tcfg_q & ~csr.csr_wmask[TIMER_W-1:0])
                       | (csr.csr_wvalue[TIMER_W-1:0] & csr.csr_wmask[TIMER_W-1:0]);

    assign en        = tcfg_q[0];
    assign periodic  = tcfg_q[1];
    assign tval_zero = (tval_q == '0);
    assign tval_ones = (tval_q == '1);
    assign load_now  = tcfg_we && tcfg_wr_val[0];

    // TICLR has no storage, so the effective write bit is just wvalue & wmask.
    assign ti_clr = ticlr_we && csr.csr_wvalue[0] && csr.csr_wmask[0];
    assign ti_set = en && tval_zero && !load_now;

    always_comb begin
        tid_d  = tid_q;
        tcfg_d = tcfg_q;
        tval_d = tval_q;
        ti_d   = ti_q;

        if (tid_we) begin
            tid_d = (tid_q & ~csr.csr_wmask) | (csr.csr_wvalue & csr.csr_wmask);
        end
        if (tcfg_we) begin
            tcfg_d = tcfg_wr_val;
        end

        // A TCFG write with En=0 freezes TVAL rather than letting it count.
        if (tcfg_we) begin
            if (tcfg_wr_val[0]) begin
                tval_d = {tcfg_wr_val[TIMER_W-1:2], 2'b00};
            end
        end else if (en && tval_zero && periodic) begin
            tval_d = {tcfg_q[TIMER_W-1:2], 2'b00};
        end else if (en && !tval_ones) begin
            tval_d = tval_q - TvalOne;
        end

        // Set beats clear so a collision never drops an interrupt.
        if (ti_set) begin
            ti_d = 1'b1;
        end else if (ti_clr) begin
            ti_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tid_q  <= TID_RESET;
            tcfg_q <= '0;
            tval_q <= '1;
            ti_q   <= 1'b0;
        end else begin
            tid_q  <= tid_d;
            tcfg_q <= tcfg_d;
            tval_q <= tval_d;
            ti_q   <= ti_d;
        end
    end

    always_comb begin
        csr.csr_rvalue = 32'h0;
        if (csr.csr_re) begin
            case (csr.csr_num)
                CsrTid:  csr.csr_rvalue = tid_q;
                CsrTcfg: csr.csr_rvalue = 32'(tcfg_q);
                CsrTval: csr.csr_rvalue = 32'(tval_q);
                default: csr.csr_rvalue = 32'h0;
            endcase
        end
    end

    assign timer_int = ti_q;

`ifdef STABLE_CNT_EN
    logic [63:0] cnt_q, cnt_d;

    assign cnt_d = cnt_q + 64'd1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= 64'h0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_value = cnt_q;
`else
    assign cnt_value = 64'h0;
`endif

endmodule
